// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

  // Arbiter FSM: IDLE waits for any requester, GRANT owns the FIFO write port.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Width of the accepted-beat debug counter; wraps naturally at all-ones.
  localparam int WR_TOTAL_W = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin search: first set bit of req starting at index start and
// wrapping modulo N_REQ. The entry just before start has the lowest priority.
module fifo_wr_arbiter_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    start,
  output logic             found,
  output logic [IW-1:0]    idx
);

  // Walk from the farthest candidate towards start so the nearest valid one wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would infer a latch.
    found = 1'b0;
    idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      int cand;
      cand = (int'(start) + i) % N_REQ;
      if (req[cand]) begin
        found = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready
// producers, with grants bounded to MAX_BURST beats.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      fifo_full,
  output logic [DATA_W-1:0]         fifo_data,
  output logic                      fifo_wr_en,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy,
  output logic [WR_TOTAL_W-1:0]     wr_total
);

  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(N_REQ - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         grant_q, grant_d;
  logic [IW-1:0]         last_q, last_d;
  logic [BW-1:0]         burst_q, burst_d;
  logic [WR_TOTAL_W-1:0] total_q, total_d;

  logic [DATA_W-1:0] data_arr [N_REQ];
  logic              in_grant;
  logic              g_valid;
  logic              beat;
  logic              release_grant;
  logic [IW-1:0]     pick_start;
  logic              pick_found;
  logic [IW-1:0]     pick_idx;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  // Unflatten the requester data bus so the granted lane can be indexed directly.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Handshake decode: a beat moves when the granted requester is valid and the FIFO has room.
  always_comb begin
    in_grant      = (state_q == GRANT);
    g_valid       = req_valid[grant_q];
    beat          = in_grant && g_valid && !fifo_full;
    release_grant = in_grant && (!g_valid || (beat && (burst_q == BURST_LAST)));
    // From IDLE search after the last owner; on release search after the current one.
    pick_start    = in_grant ? next_idx(grant_q) : next_idx(last_q);
  end

  // One shared search serves both the IDLE grant and the same-cycle re-arbitration.
  fifo_wr_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req   (req_valid),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state logic for the FSM, grant pointer, burst length and beat counter.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    burst_d = burst_q;
    total_d = total_q;
    if (beat) begin
      burst_d = burst_q + 1'b1;
      total_d = total_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          grant_d = pick_idx;
        end
      end
      GRANT: begin
        if (release_grant) begin
          last_d  = grant_q;
          burst_d = '0;
          if (pick_found) begin
            grant_d = pick_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset makes requester 0 the first winner.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_IDX;
      burst_q <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      total_q <= total_d;
    end
  end

  // Write-port outputs follow the registered grant; they drop as soon as reset clears the state.
  always_comb begin
    req_ready = '0;
    if (in_grant) begin
      req_ready[grant_q] = !fifo_full;
    end
    fifo_wr_en = beat;
    fifo_data  = data_arr[grant_q];
    grant_id   = grant_q;
    busy       = in_grant;
    wr_total   = total_q;
  end

endmodule
